// File: rtl/virtual_wire_ctrl.sv
// rtl/virtual_wire_ctrl.sv - virtual-wire work-word commit FSM and golden-nonce queue
// Work words are committed only after holding steady; nonces queue until the host pops them.
module virtual_wire_ctrl #(
  parameter int DATA_WIDTH    = 256,
  parameter int NONCE_WIDTH   = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                          hash_clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         vw_work,
  input  logic                          vw_pop_toggle,
  input  logic                          golden_valid,
  input  logic [NONCE_WIDTH-1:0]        golden_nonce,
  output logic [DATA_WIDTH-1:0]         work_data,
  output logic                          work_load,
  output logic [NONCE_WIDTH-1:0]        probe_nonce,
  output logic [$clog2(FIFO_DEPTH):0]   probe_count,
  output logic                          probe_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_COMMIT
  } state_e;

  logic [DATA_WIDTH-1:0] sync_work1_q;
  logic [DATA_WIDTH-1:0] sync_work_q;
  logic                  tog_s1_q;
  logic                  tog_s2_q;
  logic                  tog_prev_q;
  logic [1:0]            blank_q;

  always_ff @(posedge hash_clk) begin
    if (!rst_n) begin
      sync_work1_q <= '0;
      sync_work_q  <= '0;
      tog_s1_q     <= 1'b0;
      tog_s2_q     <= 1'b0;
      tog_prev_q   <= 1'b0;
      blank_q      <= 2'd3;
    end else begin
      sync_work1_q <= vw_work;
      sync_work_q  <= sync_work1_q;
      tog_s1_q     <= vw_pop_toggle;
      tog_s2_q     <= tog_s1_q;
      tog_prev_q   <= tog_s2_q;
      if (blank_q != 2'd0) begin
        blank_q <= blank_q - 2'd1;
      end
    end
  end

  // A toggle held across reset release would otherwise look like an edge.
  logic pop_req;
  assign pop_req = (tog_s2_q != tog_prev_q) && (blank_q == 2'd0);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] cand_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] work_data_q;
  logic                  work_load_q;

  always_ff @(posedge hash_clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      work_data_q <= '0;
      work_load_q <= 1'b0;
    end else begin
      work_load_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sync_work_q != work_data_q) begin
            cand_q  <= sync_work_q;
            cnt_q   <= '0;
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (sync_work_q == work_data_q) begin
            state_q <= S_IDLE;
          end else if (sync_work_q != cand_q) begin
            cand_q <= sync_work_q;
            cnt_q  <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_COMMIT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_COMMIT: begin
          work_data_q <= cand_q;
          work_load_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [NONCE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         count_q, count_d;
  logic [NONCE_WIDTH-1:0] head_q, head_d;
  logic                   ovf_q;
  logic                   pop_eff;
  logic                   push_eff;
  logic                   drop;

  always_comb begin
    pop_eff  = pop_req && (count_q != '0);
    push_eff = golden_valid && ((count_q != DEPTH_CNT) || pop_eff);
    drop     = golden_valid && !push_eff;
    wr_ptr_d = push_eff ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_eff  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    // The new head may be the nonce being written this very cycle.
    if (count_d == '0) begin
      head_d = '0;
    end else if (push_eff && (rd_ptr_d == wr_ptr_q)) begin
      head_d = golden_nonce;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge hash_clk) begin
    if (rst_n && push_eff) begin
      mem_q[wr_ptr_q] <= golden_nonce;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      ovf_q    <= ovf_q | drop;
    end
  end

  assign work_data      = work_data_q;
  assign work_load      = work_load_q;
  assign probe_nonce    = head_q;
  assign probe_count    = count_q;
  assign probe_overflow = ovf_q;

endmodule
